// File: rtl/mem_stage_unit_pkg.sv
// Shared definitions for the MEM stage: branch condition codes, access FSM
// encoding and the MEM/WB register layout.
package mem_stage_unit_pkg;

    localparam logic [2:0] COND_NEVER  = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_NE     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_GT     = 3'b110;
    localparam logic [2:0] COND_ALWAYS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic [3:0]  byte_en;
    } memwb_t;

    localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/branch_cond_eval.sv
// Maps a 3-bit branch condition code and the registered ALU flags onto a
// single "condition holds" bit.
module branch_cond_eval
    import mem_stage_unit_pkg::*;
(
    input  logic [2:0] i_condition,
    input  logic       i_less,
    input  logic       i_zero,
    output logic       o_cond_true
);

    always_comb begin
        o_cond_true = 1'b0;
        case (i_condition)
            COND_NEVER:  o_cond_true = 1'b0;
            COND_EQ:     o_cond_true = i_zero;
            COND_NE:     o_cond_true = ~i_zero;
            COND_LT:     o_cond_true = i_less;
            COND_GE:     o_cond_true = ~i_less;
            COND_LE:     o_cond_true = i_less | i_zero;
            COND_GT:     o_cond_true = ~i_less & ~i_zero;
            COND_ALWAYS: o_cond_true = 1'b1;
            default:     o_cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: branch resolution, req/ack data-memory access with
// upstream stall, and the MEM/WB pipeline register.
module mem_stage_unit
    import mem_stage_unit_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Branch_addr,
    input  logic [2:0]  Condition,
    input  logic        Branch,
    input  logic        Less,
    input  logic        Zero,
    input  logic        Overflow,
    input  logic        OverflowEn,
    input  logic [3:0]  Mem_Byte_Write,
    input  logic        MemWBSrc,
    input  logic [31:0] MemData,
    input  logic [31:0] WBData,
    input  logic [3:0]  Rd_Write_Byte_en,
    input  logic [4:0]  Rd,
    output logic        dmem_req,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] branch_target,
    output logic [31:0] WB_Data_out,
    output logic [4:0]  Rd_out,
    output logic [3:0]  Rd_Write_Byte_en_out,
    output logic        ovf_exc
);

    logic        w_kill;
    logic        w_access;
    logic        w_cond_true;
    logic        w_taken;
    logic        w_stall;
    mem_state_e  r_state;
    mem_state_e  w_state_next;
    logic        r_dmem_req;
    logic [3:0]  r_dmem_we;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic [31:0] r_load_buf;
    memwb_t      r_memwb;
    memwb_t      w_memwb_next;
    logic        r_ovf_exc;

    // An overflow trap cancels both the memory access and the branch.
    assign w_kill   = OverflowEn & Overflow;
    assign w_access = (MemWBSrc | (|Mem_Byte_Write)) & ~w_kill;

    branch_cond_eval u_branch_cond_eval (
        .i_condition (Condition),
        .i_less      (Less),
        .i_zero      (Zero),
        .o_cond_true (w_cond_true)
    );

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_stall      = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (dmem_ack) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_taken = Branch & w_cond_true & ~w_kill & (r_state == ST_IDLE);

    // Combinational pipeline controls are held low while reset is asserted.
    assign stall         = w_stall & Rst_n;
    assign flush         = w_taken & Rst_n;
    assign pc_redirect   = w_taken & Rst_n;
    assign branch_target = Branch_addr;

    // Loads take their data from the buffer captured on ack; the instruction
    // only leaves the stage in DONE, when that buffer is valid.
    always_comb begin
        w_memwb_next = MEMWB_BUBBLE;
        if (!w_stall) begin
            w_memwb_next.wb_data = MemWBSrc ? r_load_buf : WBData;
            w_memwb_next.rd      = Rd;
            w_memwb_next.byte_en = w_kill ? 4'd0 : Rd_Write_Byte_en;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= ST_IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 4'd0;
            r_dmem_addr  <= 32'd0;
            r_dmem_wdata <= 32'd0;
            r_load_buf   <= 32'd0;
            r_memwb      <= MEMWB_BUBBLE;
            r_ovf_exc    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Request fields are only written on entry to BUSY so they stay
            // stable for the whole time the request is raised.
            if ((r_state == ST_IDLE) && w_access) begin
                r_dmem_req   <= 1'b1;
                r_dmem_addr  <= WBData;
                r_dmem_wdata <= MemData;
                r_dmem_we    <= Mem_Byte_Write;
            end else if ((r_state == ST_BUSY) && dmem_ack) begin
                r_dmem_req <= 1'b0;
                r_load_buf <= dmem_rdata;
            end
            r_memwb   <= w_memwb_next;
            r_ovf_exc <= w_kill & ~w_stall;
        end
    end

    assign dmem_req             = r_dmem_req;
    assign dmem_we              = r_dmem_we;
    assign dmem_addr            = r_dmem_addr;
    assign dmem_wdata           = r_dmem_wdata;
    assign WB_Data_out          = r_memwb.wb_data;
    assign Rd_out               = r_memwb.rd;
    assign Rd_Write_Byte_en_out = r_memwb.byte_en;
    assign ovf_exc              = r_ovf_exc;

endmodule

// File: doc/mem_stage_unit.md
# mem_stage_unit

MEM-stage consumer of the EX/MEM pipeline register. Resolves conditional branches from the registered ALU flags and drives the PC redirect and pipeline flush. Performs the data-memory access through a req/ack handshake, stalling upstream stages while the access is outstanding. Owns the MEM/WB pipeline register.

## Interface
- No parameters.
- Clk  in  1  pipeline clock.
- Rst_n  in  1  asynchronous, active-low reset.
- Branch_addr  in  32  branch target from EX/MEM.
- Condition  in  3  branch condition code.
- Branch  in  1  branch instruction.
- Less, Zero, Overflow  in  1 each  ALU flags.
- OverflowEn  in  1  overflow trap enable.
- Mem_Byte_Write  in  4  store byte lanes.
- MemWBSrc  in  1  1 = writeback from memory (load).
- MemData  in  32  store data.
- WBData  in  32  ALU result; also the memory address.
- Rd_Write_Byte_en  in  4  register-file byte enables.
- Rd  in  5  destination register.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  4  byte write enables, registered.
- dmem_addr, dmem_wdata  out  32 each  registered address and data.
- dmem_ack  in  1  single-cycle completion pulse.
- dmem_rdata  in  32  read data, valid with ack.
- stall  out  1  combinational; holds IF/ID, ID/EX and EX/MEM.
- flush  out  1  combinational; clears IF/ID, ID/EX and EX/MEM.
- pc_redirect  out  1  combinational; load PC from branch_target.
- branch_target  out  32  equals Branch_addr.
- WB_Data_out  out  32  MEM/WB register.
- Rd_out  out  5  MEM/WB register.
- Rd_Write_Byte_en_out  out  4  MEM/WB register.
- ovf_exc  out  1  registered one-cycle overflow trap pulse.

## Operation
- Derived terms:
  - kill = OverflowEn & Overflow.
  - access = (MemWBSrc | |Mem_Byte_Write) & ~kill.
- Condition codes (shared package):
  - 000 never; 001 eq (Zero); 010 ne (~Zero); 011 lt (Less).
  - 100 ge (~Less); 101 le (Less|Zero); 110 gt (~Less&~Zero); 111 always.
- taken = Branch & cond_true & ~kill & state==IDLE.
  - pc_redirect = flush = taken.
- FSM states: IDLE, BUSY, DONE.
  - IDLE & access: stall=1. On the clock edge, latch dmem_addr=WBData, dmem_wdata=MemData and dmem_we=Mem_Byte_Write, set dmem_req=1, and go to BUSY.
  - BUSY: stall=1 and dmem_req stays 1. On dmem_ack: capture dmem_rdata into the load buffer, clear dmem_req, and go to DONE.
  - DONE: stall=0, then go to IDLE. EX/MEM advances on this edge.
- A store with MemWBSrc=1 is a single access; the data returned with the ack is written back.
- MEM/WB register, updated every edge:
  - When stall=1, it captures a bubble: Rd_Write_Byte_en_out=0, Rd_out=0, WB_Data_out=0.
  - Otherwise WB_Data_out = MemWBSrc ? load buffer (in DONE) : WBData, and Rd_out = Rd.
  - Rd_Write_Byte_en_out = kill ? 0 : Rd_Write_Byte_en.
- ovf_exc is registered from kill, gated by stall=0.
- A bubble (all control inputs 0) produces no access, no branch, and a bubble in MEM/WB.

## Timing
- Reset (Rst_n=0, async): state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; load buffer=0; MEM/WB outputs=0; ovf_exc=0. stall, flush and pc_redirect are forced to 0 while Rst_n=0.
- Reset during BUSY drops dmem_req immediately. An ack arriving later in IDLE is ignored.
- Access latency is 2 + N stall cycles, where N = cycles from the dmem_req rise to dmem_ack (N≥0 wait cycles; ack at the earliest in the first BUSY cycle).
- Branch resolution has 0-cycle latency. flush lasts exactly one cycle because EX/MEM becomes a bubble on the next edge.
- dmem_ack outside BUSY is ignored.
- dmem_addr, dmem_wdata and dmem_we are stable for the whole time dmem_req=1.

## Structure
- Shared pipeline package holds:
  - the Condition code constants;
  - FSM state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - a MEM/WB bubble constant.
- One natural sub-module: branch_cond_eval (combinational Condition/flags → cond_true). The FSM and MEM/WB register stay in the top.

## Test plan
- Branch=1, Condition=001, Zero=1, Branch_addr=0x0040_0100 → same cycle flush=1, pc_redirect=1, branch_target=0x0040_0100. With Zero=0 → flush=0.
- Load: MemWBSrc=1, WBData=0x1000, Rd=5, Rd_Write_Byte_en=4'hF, ack 3 cycles after req, rdata=0xDEAD_BEEF:
  - stall=1 for 5 cycles; dmem_addr=0x1000, dmem_we=0;
  - then WB_Data_out=0xDEAD_BEEF, Rd_out=5.
- Store: Mem_Byte_Write=4'b0011, MemData=0x1234_5678, ack in the first BUSY cycle → stall=1 for exactly 2 cycles, dmem_we=4'b0011, dmem_wdata=0x1234_5678.
- OverflowEn=1, Overflow=1, Mem_Byte_Write=4'hF, Branch=1, Condition=111 → no dmem_req, flush=0, ovf_exc pulses once, Rd_Write_Byte_en_out=0.
- Rst_n pulled low during BUSY → dmem_req=0 immediately, all outputs at reset values; a late ack after release causes no state change.
- Back-to-back loads with 0 wait cycles → each load gets its own req pulse; MEM/WB shows one bubble per stall cycle and the correct data in order.
